flash_cmd_seq: RTL and testbench
================================

FLASH_CMD_SEQ -- requirements
Module: flash_cmd_seq

Interface
REQ-001 Parameter PROG_WAIT, default 20: SCL cycles waited after the last program write cycle.
REQ-002 Parameter ERASE_WAIT, default 200: SCL cycles waited after the last erase write cycle.
REQ-003 SCL  in  1  sole clock; all state SHALL update on posedge SCL.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 StartRead / StartProg / StartSectErase / StartChipErase  in  1 each  operation requests, sampled in IDLE.
REQ-006 AutoIncr  in  1  pulse IncrAddr after a completed read or program.
REQ-007 WrData  in  8  user byte for the program data cycle.
REQ-008 Sel5555 / SelAAAA / SelAddr / SelHOLD / SelXXXX  out  1 each  address-unit selects.
REQ-009 IncrAddr  out  1  address-unit increment strobe.
REQ-010 FlashDQ  out  8  byte driven to flash during write cycles.
REQ-011 CE_n / WE_n / OE_n  out  1 each  flash strobes, active low.
REQ-012 ReadStrobe  out  1  one-cycle pulse: flash read data valid.
REQ-013 Busy / Done / Error  out  1 each  status.

Function
REQ-014 States SHALL be IDLE, SETUP, STROBE, HOLD, WAIT, READ_OE, INCR, DONE; all outputs SHALL be Moore-decoded from registered state, so they are stable at the following negedge SCL, where the address unit samples them.
REQ-015 Exactly one of Sel5555/SelAAAA/SelAddr/SelHOLD/SelXXXX SHALL be high in every cycle; SelXXXX in IDLE and DONE, SelHOLD in WAIT.
REQ-016 Start priority when several are high: StartChipErase > StartSectErase > StartProg > StartRead; a start accepted at edge k SHALL give SETUP and Busy=1 at k+1.
REQ-017 Any Start high while Busy=1 SHALL be ignored and SHALL pulse Error for one cycle; Error SHALL NOT alter the running operation.
REQ-018 Each write cycle SHALL take 3 cycles: SETUP (CE_n=0, WE_n=1), STROBE (WE_n=0), HOLD (WE_n=1); select and FlashDQ SHALL be constant across all 3.
REQ-019 Program sequence: (5555,AA) (AAAA,55) (5555,A0) (Addr,WrData), then WAIT for PROG_WAIT cycles.
REQ-020 Sector erase: (5555,AA) (AAAA,55) (5555,80) (5555,AA) (AAAA,55) (Addr,30), then WAIT for ERASE_WAIT cycles.
REQ-021 Chip erase: as REQ-020 with a final (5555,10), then WAIT for ERASE_WAIT cycles.
REQ-022 WrData SHALL be captured when the start is accepted; later changes SHALL be ignored.
REQ-023 Read: SETUP with SelAddr and CE_n=0, then READ_OE for 2 cycles with OE_n=0; ReadStrobe=1 in the second READ_OE cycle only; WE_n stays 1.
REQ-024 After a read or program, if AutoIncr was high at start, INCR SHALL last 1 cycle with IncrAddr=1 and SelAddr=1; otherwise INCR is skipped.
REQ-025 DONE SHALL last 1 cycle with Done=1, CE_n=1, Busy=0, then return to IDLE; a Start in DONE SHALL be ignored without Error.
REQ-026 Wait counter SHALL be 16 bits; a wait of 0 SHALL go straight from HOLD to INCR/DONE.
REQ-027 IDLE outputs: CE_n=WE_n=OE_n=1, FlashDQ=8'h00, Busy=0.
REQ-028 Total latency start-to-Done: program 12+PROG_WAIT(+1 if AutoIncr)+1; sector erase 18+ERASE_WAIT+1; chip erase 21+ERASE_WAIT+1; read 3(+1)+1.

Reset
REQ-029 Reset=1 at posedge SCL SHALL force IDLE and the REQ-027 values plus SelXXXX=1, other selects 0, IncrAddr=ReadStrobe=Done=Error=0, counters 0.
REQ-030 Reset mid-operation SHALL abort with no Done pulse; WE_n and OE_n SHALL be 1 from the next cycle.
REQ-031 Reset SHALL override any simultaneous Start.

Structure
REQ-032 Package flash_cmd_pkg SHALL hold the command bytes (AA, 55, A0, 80, 30, 10), the state encoding, the op encoding and the address-select encoding.
REQ-033 Sub-module flash_cmd_rom SHALL be combinational: (op, step) -> (select, data source, last-step flag).

Verification
REQ-034 Program, WrData=8'h3C, AutoIncr=1, PROG_WAIT=20 -> 4 WE_n low pulses with (Sel5555,AA)(SelAAAA,55)(Sel5555,A0)(SelAddr,3C); IncrAddr 1 cycle; Done at cycle 34.
REQ-035 Sector erase, ERASE_WAIT=200 -> 6 write cycles ending (SelAddr,30); SelHOLD for 200 cycles; Done at cycle 219.
REQ-036 StartRead with AutoIncr=0 -> OE_n low for 2 cycles; ReadStrobe in the 2nd; WE_n never low; Done at cycle 4.
REQ-037 StartProg and StartChipErase high in the same cycle -> chip-erase sequence runs; a StartRead at cycle 5 -> Error pulse, sequence unchanged.
REQ-038 Reset during STROBE of the 3rd program write -> WE_n=1, SelXXXX=1, Busy=0 next cycle; no Done; new StartProg then completes normally.
REQ-039 A one-hot select check runs on every cycle of all of the above.

Source files
------------

// File: rtl/flash_cmd_pkg.sv
// flash_cmd_pkg
// Shared definitions for the flash command sequencer: the JEDEC-style command
// bytes, the sequencer state encoding, the operation encoding, the select
// encoding for the external address unit, and the data-source encoding used
// by the command ROM.
// No ports (package).
package flash_cmd_pkg;

    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_55 = 8'h55;
    localparam logic [7:0] CMD_A0 = 8'hA0;
    localparam logic [7:0] CMD_80 = 8'h80;
    localparam logic [7:0] CMD_30 = 8'h30;
    localparam logic [7:0] CMD_10 = 8'h10;

    localparam int STEP_W = 3;
    localparam int WAIT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_WAIT,
        ST_READ_OE,
        ST_INCR,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_PROG,
        OP_SECT_ERASE,
        OP_CHIP_ERASE
    } op_t;

    typedef enum logic [2:0] {
        SEL_XXXX,
        SEL_5555,
        SEL_AAAA,
        SEL_ADDR,
        SEL_HOLD
    } sel_t;

    typedef enum logic {
        SRC_CMD,
        SRC_WRDATA
    } src_t;

endpackage

// File: rtl/flash_cmd_seq_if.sv
// flash_cmd_seq_if
// Bundles the operation requests, the address-unit selects, the flash strobes
// and the status flags of the flash command sequencer.
//   master modport : drives StartRead/StartProg/StartSectErase/StartChipErase,
//                    AutoIncr, WrData; observes everything else.
//   slave modport  : the sequencer side (flash_cmd_seq).
interface flash_cmd_seq_if;

    logic       StartRead;
    logic       StartProg;
    logic       StartSectErase;
    logic       StartChipErase;
    logic       AutoIncr;
    logic [7:0] WrData;

    logic       Sel5555;
    logic       SelAAAA;
    logic       SelAddr;
    logic       SelHOLD;
    logic       SelXXXX;
    logic       IncrAddr;
    logic [7:0] FlashDQ;
    logic       CE_n;
    logic       WE_n;
    logic       OE_n;
    logic       ReadStrobe;
    logic       Busy;
    logic       Done;
    logic       Error;

    modport master (
        output StartRead, StartProg, StartSectErase, StartChipErase, AutoIncr, WrData,
        input  Sel5555, SelAAAA, SelAddr, SelHOLD, SelXXXX, IncrAddr, FlashDQ,
        input  CE_n, WE_n, OE_n, ReadStrobe, Busy, Done, Error
    );

    modport slave (
        input  StartRead, StartProg, StartSectErase, StartChipErase, AutoIncr, WrData,
        output Sel5555, SelAAAA, SelAddr, SelHOLD, SelXXXX, IncrAddr, FlashDQ,
        output CE_n, WE_n, OE_n, ReadStrobe, Busy, Done, Error
    );

endinterface

// File: rtl/flash_cmd_rom.sv
// flash_cmd_rom
// Combinational command table: for a given operation and write-cycle index it
// returns the address select, where the data byte comes from, the constant
// command byte, and whether this is the final write cycle of the operation.
// Ports:
//   op   in  operation being executed
//   step in  write-cycle index within the operation
//   sel  out address-unit select for this write cycle
//   src  out data source (command constant or captured user byte)
//   cmd  out command byte when src is SRC_CMD
//   last out high on the final write cycle
module flash_cmd_rom
    import flash_cmd_pkg::*;
(
    input  op_t               op,
    input  logic [STEP_W-1:0] step,
    output sel_t              sel,
    output src_t              src,
    output logic [7:0]        cmd,
    output logic              last
);

    // Both erase flavours share the first six cycles; chip erase appends one
    // extra (5555,10) cycle after the (Addr,30) cycle.
    always_comb begin
        sel  = SEL_XXXX;
        src  = SRC_CMD;
        cmd  = 8'h00;
        last = 1'b1;
        case (op)
            OP_READ: begin
                sel  = SEL_ADDR;
                last = 1'b1;
            end
            OP_PROG: begin
                last = 1'b0;
                case (step)
                    3'd0: begin sel = SEL_5555; cmd = CMD_AA; end
                    3'd1: begin sel = SEL_AAAA; cmd = CMD_55; end
                    3'd2: begin sel = SEL_5555; cmd = CMD_A0; end
                    default: begin sel = SEL_ADDR; src = SRC_WRDATA; last = 1'b1; end
                endcase
            end
            default: begin
                last = 1'b0;
                case (step)
                    3'd0: begin sel = SEL_5555; cmd = CMD_AA; end
                    3'd1: begin sel = SEL_AAAA; cmd = CMD_55; end
                    3'd2: begin sel = SEL_5555; cmd = CMD_80; end
                    3'd3: begin sel = SEL_5555; cmd = CMD_AA; end
                    3'd4: begin sel = SEL_AAAA; cmd = CMD_55; end
                    3'd5: begin
                        sel  = SEL_ADDR;
                        cmd  = CMD_30;
                        last = (op == OP_SECT_ERASE);
                    end
                    default: begin sel = SEL_5555; cmd = CMD_10; last = 1'b1; end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/flash_cmd_seq.sv
// flash_cmd_seq
// Sequences flash read, program, sector-erase and chip-erase operations as a
// series of 3-cycle write cycles (SETUP/STROBE/HOLD) followed by a wait, and
// drives an external address unit through one-hot selects. Every output is
// decoded from registered state so it is stable at the following negedge SCL.
// Ports:
//   SCL   in  sole clock, all state updates on posedge
//   Reset in  synchronous active-high reset
//   bus   slave side of flash_cmd_seq_if (requests, selects, strobes, status)
module flash_cmd_seq
    import flash_cmd_pkg::*;
#(
    parameter int PROG_WAIT  = 20,
    parameter int ERASE_WAIT = 200
) (
    input logic           SCL,
    input logic           Reset,
    flash_cmd_seq_if.slave bus
);

    localparam logic [WAIT_W-1:0] PROG_WAIT_CNT  = WAIT_W'(PROG_WAIT);
    localparam logic [WAIT_W-1:0] ERASE_WAIT_CNT = WAIT_W'(ERASE_WAIT);

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [7:0]          wrdata_q, wrdata_d;
    logic                auto_q, auto_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                rd_second_q, rd_second_d;
    logic                error_q;

    sel_t                rom_sel;
    src_t                rom_src;
    logic [7:0]          rom_cmd;
    logic                rom_last;

    sel_t                sel;
    logic                busy;
    logic                any_start;
    logic [WAIT_W-1:0]   wait_len;
    state_t              after_op;

    flash_cmd_rom u_rom (
        .op   (op_q),
        .step (step_q),
        .sel  (rom_sel),
        .src  (rom_src),
        .cmd  (rom_cmd),
        .last (rom_last)
    );

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign any_start = bus.StartRead | bus.StartProg | bus.StartSectErase | bus.StartChipErase;
    assign wait_len  = (op_q == OP_PROG) ? PROG_WAIT_CNT : ERASE_WAIT_CNT;
    // The address increment only makes sense after a read or program.
    assign after_op  = (auto_q && (op_q == OP_READ || op_q == OP_PROG)) ? ST_INCR : ST_DONE;

    // State and operation context registers. The Error flag is a registered
    // one-cycle echo of a request arriving while an operation is in flight.
    always_ff @(posedge SCL) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            wrdata_q    <= 8'h00;
            auto_q      <= 1'b0;
            step_q      <= '0;
            cnt_q       <= '0;
            rd_second_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wrdata_q    <= wrdata_d;
            auto_q      <= auto_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            rd_second_q <= rd_second_d;
            error_q     <= busy & any_start;
        end
    end

    // Next-state logic. The wait counter is loaded with length-1 on leaving
    // the final HOLD so that WAIT lasts exactly the configured number of cycles.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wrdata_d    = wrdata_q;
        auto_d      = auto_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        rd_second_d = rd_second_q;
        case (state_q)
            ST_IDLE: begin
                if (any_start) begin
                    if (bus.StartChipErase)      op_d = OP_CHIP_ERASE;
                    else if (bus.StartSectErase) op_d = OP_SECT_ERASE;
                    else if (bus.StartProg)      op_d = OP_PROG;
                    else                         op_d = OP_READ;
                    wrdata_d = bus.WrData;
                    auto_d   = bus.AutoIncr;
                    step_d   = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                rd_second_d = 1'b0;
                state_d     = (op_q == OP_READ) ? ST_READ_OE : ST_STROBE;
            end
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!rom_last) begin
                    step_d  = step_q + 3'd1;
                    state_d = ST_SETUP;
                end else if (wait_len == '0) begin
                    state_d = after_op;
                end else begin
                    cnt_d   = wait_len - 16'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = after_op;
                else             cnt_d   = cnt_q - 16'd1;
            end
            ST_READ_OE: begin
                if (rd_second_q) state_d     = after_op;
                else             rd_second_d = 1'b1;
            end
            ST_INCR: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; the select and data byte come from the ROM for the
    // whole SETUP/STROBE/HOLD triple, so they cannot change mid write cycle.
    always_comb begin
        sel            = SEL_XXXX;
        bus.CE_n       = 1'b1;
        bus.WE_n       = 1'b1;
        bus.OE_n       = 1'b1;
        bus.FlashDQ    = 8'h00;
        bus.IncrAddr   = 1'b0;
        bus.ReadStrobe = 1'b0;
        case (state_q)
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                sel         = rom_sel;
                bus.CE_n    = 1'b0;
                bus.WE_n    = (state_q != ST_STROBE);
                bus.FlashDQ = (rom_src == SRC_WRDATA) ? wrdata_q : rom_cmd;
            end
            ST_WAIT: sel = SEL_HOLD;
            ST_READ_OE: begin
                sel            = SEL_ADDR;
                bus.CE_n       = 1'b0;
                bus.OE_n       = 1'b0;
                bus.ReadStrobe = rd_second_q;
            end
            ST_INCR: begin
                sel          = SEL_ADDR;
                bus.IncrAddr = 1'b1;
            end
            default: sel = SEL_XXXX;
        endcase
    end

    assign bus.Sel5555 = (sel == SEL_5555);
    assign bus.SelAAAA = (sel == SEL_AAAA);
    assign bus.SelAddr = (sel == SEL_ADDR);
    assign bus.SelHOLD = (sel == SEL_HOLD);
    assign bus.SelXXXX = (sel == SEL_XXXX);
    assign bus.Busy    = busy;
    assign bus.Done    = (state_q == ST_DONE);
    assign bus.Error   = error_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb_flash_cmd_seq
// Directed self-checking bench for flash_cmd_seq: reset values, program,
// read, sector erase, chip erase with a colliding request, and reset abort.
// A monitor samples every cycle shortly after posedge SCL, checks that exactly
// one select is high and records write cycles and strobe activity.
module tb_flash_cmd_seq;

    logic SCL = 1'b0;
    logic Reset;

    flash_cmd_seq_if bus ();

    flash_cmd_seq #(
        .PROG_WAIT  (20),
        .ERASE_WAIT (200)
    ) dut (
        .SCL   (SCL),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 SCL = ~SCL;

    int checks = 0;
    int errors = 0;

    // Monitor state: write cycles as {select code, byte}; select codes are
    // 0=XXXX 1=5555 2=AAAA 3=Addr 4=HOLD.
    logic [10:0] writes[$];
    logic [10:0] exp_writes[$];
    int incr_cycles, oe_cycles, oe_run, rs_cycles, rs_pos;
    int hold_cycles, done_cycles, err_cycles;
    logic we_prev = 1'b1;
    bit mon_on = 1'b0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] sel_code();
        if (bus.Sel5555) return 3'd1;
        if (bus.SelAAAA) return 3'd2;
        if (bus.SelAddr) return 3'd3;
        if (bus.SelHOLD) return 3'd4;
        return 3'd0;
    endfunction

    // Per-cycle monitor, sampling 2 time units after the active edge.
    always @(posedge SCL) begin
        #2;
        if (mon_on) begin
            check_output("onehot_sel",
                         $countones({bus.Sel5555, bus.SelAAAA, bus.SelAddr, bus.SelHOLD, bus.SelXXXX}),
                         32'd1);
            if (bus.WE_n === 1'b0 && we_prev === 1'b1)
                writes.push_back({sel_code(), bus.FlashDQ});
            we_prev = bus.WE_n;
            if (bus.IncrAddr) incr_cycles++;
            if (bus.OE_n === 1'b0) begin
                oe_run++;
                oe_cycles++;
            end else begin
                oe_run = 0;
            end
            if (bus.ReadStrobe) begin
                rs_cycles++;
                rs_pos = oe_run;
            end
            if (bus.SelHOLD) hold_cycles++;
            if (bus.Done) done_cycles++;
            if (bus.Error) err_cycles++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_stats();
        writes.delete();
        incr_cycles = 0; oe_cycles = 0; oe_run = 0; rs_cycles = 0; rs_pos = 0;
        hold_cycles = 0; done_cycles = 0; err_cycles = 0;
    endtask

    // Presents a start pulse for exactly one sampling edge, then scrambles
    // WrData so a late capture would be visible. Returns at the negedge of
    // cycle 1 (the first cycle after acceptance).
    task automatic apply_stimulus(input logic rd, input logic prog, input logic sect,
                                  input logic chip, input logic auto_incr,
                                  input logic [7:0] data);
        @(negedge SCL);
        bus.StartRead      = rd;
        bus.StartProg      = prog;
        bus.StartSectErase = sect;
        bus.StartChipErase = chip;
        bus.AutoIncr       = auto_incr;
        bus.WrData         = data;
        @(negedge SCL);
        bus.StartRead      = 1'b0;
        bus.StartProg      = 1'b0;
        bus.StartSectErase = 1'b0;
        bus.StartChipErase = 1'b0;
        bus.AutoIncr       = ~auto_incr;
        bus.WrData         = ~data;
    endtask

    task automatic wait_done(input int first, input int budget, output int n);
        n = first;
        while (bus.Done !== 1'b1 && n < budget) begin
            @(negedge SCL);
            n++;
        end
    endtask

    task automatic check_writes(input string tag);
        check_output({tag, "_nwrites"}, writes.size(), exp_writes.size());
        for (int i = 0; i < exp_writes.size(); i++)
            check_output($sformatf("%s_w%0d", tag, i),
                         (i < writes.size()) ? {21'd0, writes[i]} : 32'hFFFF_FFFF,
                         {21'd0, exp_writes[i]});
    endtask

    initial begin
        int n;
        Reset              = 1'b1;
        bus.StartRead      = 1'b0;
        bus.StartProg      = 1'b0;
        bus.StartSectErase = 1'b0;
        bus.StartChipErase = 1'b0;
        bus.AutoIncr       = 1'b0;
        bus.WrData         = 8'h00;
        clear_stats();

        // Reset values
        repeat (2) @(negedge SCL);
        mon_on = 1'b1;
        check_output("rst_CE_n", bus.CE_n, 1);
        check_output("rst_WE_n", bus.WE_n, 1);
        check_output("rst_OE_n", bus.OE_n, 1);
        check_output("rst_FlashDQ", bus.FlashDQ, 8'h00);
        check_output("rst_Busy", bus.Busy, 0);
        check_output("rst_Done", bus.Done, 0);
        check_output("rst_Error", bus.Error, 0);
        check_output("rst_IncrAddr", bus.IncrAddr, 0);
        check_output("rst_ReadStrobe", bus.ReadStrobe, 0);
        check_output("rst_SelXXXX", bus.SelXXXX, 1);

        // Reset overrides a simultaneous start
        bus.StartProg = 1'b1;
        @(negedge SCL);
        bus.StartProg = 1'b0;
        check_output("rst_over_start_busy", bus.Busy, 0);
        Reset = 1'b0;
        @(negedge SCL);
        check_output("idle_after_rst_busy", bus.Busy, 0);

        // Program, WrData=3C, AutoIncr=1
        $display("[TB] program with auto-increment");
        clear_stats();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
        check_output("prog_busy_setup", bus.Busy, 1);
        check_output("prog_setup_WE_n", bus.WE_n, 1);
        check_output("prog_setup_CE_n", bus.CE_n, 0);
        wait_done(1, 60, n);
        check_output("prog_done_cycle", n, 34);
        check_output("prog_done_busy", bus.Busy, 0);
        check_output("prog_done_CE_n", bus.CE_n, 1);
        @(negedge SCL);
        check_output("prog_idle_done", bus.Done, 0);
        exp_writes = '{{3'd1, 8'hAA}, {3'd2, 8'h55}, {3'd1, 8'hA0}, {3'd3, 8'h3C}};
        check_writes("prog");
        check_output("prog_incr_cycles", incr_cycles, 1);
        check_output("prog_hold_cycles", hold_cycles, 20);
        check_output("prog_oe_cycles", oe_cycles, 0);
        check_output("prog_err_cycles", err_cycles, 0);

        // Read, AutoIncr=0, plus a start during DONE that must be ignored
        $display("[TB] read without auto-increment");
        clear_stats();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        wait_done(1, 30, n);
        check_output("read_done_cycle", n, 4);
        bus.StartRead = 1'b1;
        @(negedge SCL);
        bus.StartRead = 1'b0;
        check_output("start_in_done_busy", bus.Busy, 0);
        check_output("start_in_done_error", bus.Error, 0);
        @(negedge SCL);
        check_output("start_in_done_idle", bus.Busy, 0);
        check_output("read_oe_cycles", oe_cycles, 2);
        check_output("read_rs_cycles", rs_cycles, 1);
        check_output("read_rs_pos", rs_pos, 2);
        check_output("read_nwrites", writes.size(), 0);
        check_output("read_incr_cycles", incr_cycles, 0);
        check_output("read_err_cycles", err_cycles, 0);

        // Sector erase
        $display("[TB] sector erase");
        clear_stats();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        wait_done(1, 260, n);
        check_output("sect_done_cycle", n, 219);
        @(negedge SCL);
        exp_writes = '{{3'd1, 8'hAA}, {3'd2, 8'h55}, {3'd1, 8'h80},
                       {3'd1, 8'hAA}, {3'd2, 8'h55}, {3'd3, 8'h30}};
        check_writes("sect");
        check_output("sect_hold_cycles", hold_cycles, 200);
        check_output("sect_incr_cycles", incr_cycles, 0);

        // Chip erase wins over program; a read request mid-run raises Error
        $display("[TB] chip erase with colliding requests");
        clear_stats();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        repeat (3) @(negedge SCL);
        bus.StartRead = 1'b1;
        @(negedge SCL);
        bus.StartRead = 1'b0;
        check_output("chip_error_pulse", bus.Error, 1);
        check_output("chip_busy_at_error", bus.Busy, 1);
        wait_done(5, 260, n);
        check_output("chip_done_cycle", n, 222);
        @(negedge SCL);
        exp_writes = '{{3'd1, 8'hAA}, {3'd2, 8'h55}, {3'd1, 8'h80}, {3'd1, 8'hAA},
                       {3'd2, 8'h55}, {3'd3, 8'h30}, {3'd1, 8'h10}};
        check_writes("chip");
        check_output("chip_err_cycles", err_cycles, 1);
        check_output("chip_hold_cycles", hold_cycles, 200);
        check_output("chip_incr_cycles", incr_cycles, 0);

        // Reset during STROBE of the third program write
        $display("[TB] reset abort during program");
        clear_stats();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h96);
        repeat (7) @(negedge SCL);
        check_output("abort_in_strobe_WE_n", bus.WE_n, 0);
        check_output("abort_in_strobe_Sel5555", bus.Sel5555, 1);
        Reset = 1'b1;
        @(negedge SCL);
        Reset = 1'b0;
        check_output("abort_WE_n", bus.WE_n, 1);
        check_output("abort_OE_n", bus.OE_n, 1);
        check_output("abort_SelXXXX", bus.SelXXXX, 1);
        check_output("abort_Busy", bus.Busy, 0);
        repeat (40) @(negedge SCL);
        check_output("abort_no_done", done_cycles, 0);

        clear_stats();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        wait_done(1, 60, n);
        check_output("reprog_done_cycle", n, 33);
        @(negedge SCL);
        exp_writes = '{{3'd1, 8'hAA}, {3'd2, 8'h55}, {3'd1, 8'hA0}, {3'd3, 8'h5A}};
        check_writes("reprog");
        check_output("reprog_incr_cycles", incr_cycles, 0);
        check_output("reprog_hold_cycles", hold_cycles, 20);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
